// File: rtl/lab5_pkg.sv
// ============================================================================
// Module  : lab5_pkg
// Brief   : Shared state codes, error codes and default sizes for lab5_host.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package lab5_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_VERIFY = 3'd2;
    localparam state_t ST_KICK   = 3'd3;
    localparam state_t ST_WAIT   = 3'd4;
    localparam state_t ST_REPORT = 3'd5;

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_SUM  = 2'd1;
    localparam logic [1:0] ERR_RDBK = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam int DEF_DEPTH = 6;
    localparam int DEF_AW    = 3;
    localparam int DEF_DW    = 8;

endpackage

`default_nettype wire

// File: rtl/lab5_host_timeout.sv
// ============================================================================
// Module  : lab5_host_timeout
// Brief   : Loadable up-counter with clear and enable; expired at LIMIT.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lab5_host_timeout #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 254
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (ld) begin
            count_d = ld_val;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == WIDTH'(LIMIT));

endmodule

`default_nettype wire

// File: rtl/lab5_host.sv
// ============================================================================
// Module  : lab5_host
// Brief   : Host driver for the lab5 sum engine: load, optional readback,
//           start, wait for done, compare ans with the local sum.
//           Optional readback stage enabled by LAB5_HOST_READBACK_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lab5_host
    import lab5_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [AW-1:0] addr,
    output logic          we,
    output logic [DW-1:0] din,
    output logic          re,
    input  logic [DW-1:0] dout,
    output logic          start,
    input  logic          done,
    input  logic [DW-1:0] ans,
    output logic          busy,
    output logic [DW-1:0] result,
    output logic          result_valid,
    output logic          pass,
    output logic [1:0]    err_code
);

    localparam int IW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] acc_q, acc_d;
    logic          in_ready_q, in_ready_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] din_q, din_d;
    logic          start_q, start_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] result_q, result_d;
    logic          result_valid_q, result_valid_d;
    logic          pass_q, pass_d;
    logic [1:0]    err_q, err_d;

    logic          w_tmr_clr;
    logic          w_tmr_en;
    logic          w_tmr_expired;
    logic [1:0]    w_final_err;

`ifdef LAB5_HOST_READBACK_EN
    logic          re_q, re_d;
    logic          chk_q, chk_d;
    logic [AW-1:0] chk_addr_q, chk_addr_d;
    logic [DW-1:0] shadow_q [0:(1<<AW)-1];
    logic [DW-1:0] shadow_d [0:(1<<AW)-1];
`endif

    // A readback error already latched takes priority over a sum mismatch.
    assign w_final_err = ((err_q == ERR_OK) && (ans != acc_q)) ? ERR_SUM : err_q;

    lab5_host_timeout #(
        .WIDTH (TW),
        .LIMIT (TIMEOUT - 1)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_tmr_clr),
        .en      (w_tmr_en),
        .ld      (1'b0),
        .ld_val  ({TW{1'b0}}),
        .expired (w_tmr_expired)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        acc_d          = acc_q;
        in_ready_d     = in_ready_q;
        addr_d         = addr_q;
        we_d           = 1'b0;
        din_d          = din_q;
        start_d        = 1'b0;
        result_d       = result_q;
        result_valid_d = 1'b0;
        pass_d         = pass_q;
        err_d          = err_q;
        w_tmr_clr      = 1'b0;
        w_tmr_en       = 1'b0;
`ifdef LAB5_HOST_READBACK_EN
        re_d       = 1'b0;
        chk_d      = re_q;
        chk_addr_d = addr_q;
        shadow_d   = shadow_q;
        // Read data returns the cycle after re; the last compare lands in KICK.
        if (chk_q && (dout != shadow_q[chk_addr_q]) && (err_q == ERR_OK)) begin
            err_d = ERR_RDBK;
        end
`endif

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    idx_d      = '0;
                    acc_d      = '0;
                    pass_d     = 1'b0;
                    err_d      = ERR_OK;
                    result_d   = '0;
                    in_ready_d = 1'b1;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_valid && in_ready_q) begin
                    we_d   = 1'b1;
                    addr_d = idx_q[AW-1:0];
                    din_d  = in_data;
                    acc_d  = acc_q + in_data;
`ifdef LAB5_HOST_READBACK_EN
                    shadow_d[idx_q[AW-1:0]] = in_data;
`endif
                    if (idx_q == IW'(DEPTH - 1)) begin
                        idx_d      = '0;
                        in_ready_d = 1'b0;
`ifdef LAB5_HOST_READBACK_EN
                        state_d    = ST_VERIFY;
`else
                        state_d    = ST_KICK;
                        start_d    = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef LAB5_HOST_READBACK_EN
            ST_VERIFY: begin
                // First VERIFY cycle carries the final write; reads follow.
                if (idx_q == IW'(DEPTH)) begin
                    idx_d   = '0;
                    start_d = 1'b1;
                    state_d = ST_KICK;
                end else begin
                    re_d   = 1'b1;
                    addr_d = idx_q[AW-1:0];
                    idx_d  = idx_q + 1'b1;
                end
            end
`endif
            ST_KICK: begin
                w_tmr_clr = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                w_tmr_en = 1'b1;
                if (done) begin
                    result_d       = ans;
                    err_d          = w_final_err;
                    pass_d         = (w_final_err == ERR_OK);
                    result_valid_d = 1'b1;
                    state_d        = ST_REPORT;
                end else if (w_tmr_expired) begin
                    result_d       = '0;
                    err_d          = ERR_TMO;
                    pass_d         = 1'b0;
                    result_valid_d = 1'b1;
                    state_d        = ST_REPORT;
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            acc_q          <= '0;
            in_ready_q     <= 1'b0;
            addr_q         <= '0;
            we_q           <= 1'b0;
            din_q          <= '0;
            start_q        <= 1'b0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            pass_q         <= 1'b0;
            err_q          <= ERR_OK;
`ifdef LAB5_HOST_READBACK_EN
            re_q           <= 1'b0;
            chk_q          <= 1'b0;
            chk_addr_q     <= '0;
            shadow_q       <= '{default: '0};
`endif
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            acc_q          <= acc_d;
            in_ready_q     <= in_ready_d;
            addr_q         <= addr_d;
            we_q           <= we_d;
            din_q          <= din_d;
            start_q        <= start_d;
            busy_q         <= busy_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            pass_q         <= pass_d;
            err_q          <= err_d;
`ifdef LAB5_HOST_READBACK_EN
            re_q           <= re_d;
            chk_q          <= chk_d;
            chk_addr_q     <= chk_addr_d;
            shadow_q       <= shadow_d;
`endif
        end
    end

`ifdef LAB5_HOST_READBACK_EN
    assign re = re_q;
`else
    logic w_unused_dout;
    assign re            = 1'b0;
    assign w_unused_dout = ^dout;
`endif

    assign in_ready     = in_ready_q;
    assign addr         = addr_q;
    assign we           = we_q;
    assign din          = din_q;
    assign start        = start_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign pass         = pass_q;
    assign err_code     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_lab5_host.sv
// ============================================================================
// Module  : tb_lab5_host
// Brief   : Directed self-checking bench for lab5_host with an engine model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lab5_host;

    typedef logic [7:0] bytes_t [6];

    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [2:0] addr;
    logic       we;
    logic [7:0] din;
    logic       re;
    logic [7:0] dout = 8'd0;
    logic       start;
    logic       done = 1'b0;
    logic [7:0] ans;
    logic       busy;
    logic [7:0] result;
    logic       result_valid;
    logic       pass;
    logic [1:0] err_code;

    int n_tests = 0;
    int n_fail  = 0;

    lab5_host #(
        .DEPTH   (6),
        .AW      (3),
        .DW      (8),
        .TIMEOUT (255)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .addr         (addr),
        .we           (we),
        .din          (din),
        .re           (re),
        .dout         (dout),
        .start        (start),
        .done         (done),
        .ans          (ans),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .pass         (pass),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    // Engine model: registered memory, done k cycles after start.
    logic [7:0] mem [8];
    int         eng_k     = 2;
    logic [7:0] eng_ans   = 8'd0;
    bit         eng_never = 1'b0;
    bit         eng_bad1  = 1'b0;
    int         eng_cnt   = 0;

    assign ans = done ? eng_ans : 8'hEE;

    always @(posedge clk) begin
        if (we) mem[addr] <= din;
        if (re) dout <= (eng_bad1 && addr == 3'd1) ? 8'd21 : mem[addr];
        done <= 1'b0;
        if (start && !eng_never) begin
            if (eng_k <= 1) done <= 1'b1;
            else eng_cnt <= eng_k - 1;
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) done <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_start"}, start, 0);
        check({tag, "_we"}, we, 0);
        check({tag, "_re"}, re, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_din"}, din, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_rv"}, result_valid, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, err_code, 0);
    endtask

    task automatic run_txn(input string tag, input bytes_t b, input int k,
                           input logic [7:0] a, input bit never, input bit bad1,
                           input int gap, input bit rst_wait,
                           input logic [7:0] exp_res, input logic [1:0] exp_err,
                           input bit exp_pass, input int exp_lat);
        int n;
        int st;
        int starts;
        eng_k     = k;
        eng_ans   = a;
        eng_never = never;
        eng_bad1  = bad1;

        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        check({tag, "_go_in_ready"}, in_ready, 1);
        check({tag, "_go_busy"}, busy, 1);

        for (int i = 0; i < 6; i++) begin
            if (i == gap) begin
                @(negedge clk);
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                check({tag, "_gap_we"}, we, 0);
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b[i];
            @(posedge clk);
            #1;
            check({tag, "_we"}, we, 1);
            check({tag, "_addr"}, addr, i);
            check({tag, "_din"}, din, b[i]);
            check({tag, "_in_ready"}, in_ready, (i != 5));
        end
        in_valid = 1'b0;

        if (rst_wait) begin
            repeat (12) @(posedge clk);
            #1;
            check({tag, "_wait_busy"}, busy, 1);
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            check_idle_outputs({tag, "_rst"});
            return;
        end

        n      = 0;
        st     = -1;
        starts = 0;
        while (1) begin
            if (start) begin
                starts++;
                if (st < 0) st = n;
            end
            if (result_valid || n >= 1000) break;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_rv_seen"}, result_valid, 1);
        check({tag, "_starts"}, starts, 1);
        check({tag, "_lat"}, n - st, exp_lat);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_err"}, err_code, exp_err);
        check({tag, "_pass"}, pass, exp_pass);
        @(posedge clk);
        #1;
        check({tag, "_rv_pulse"}, result_valid, 0);
        check({tag, "_pass_hold"}, pass, exp_pass);
        check({tag, "_err_hold"}, err_code, exp_err);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    bytes_t b_a = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
    bytes_t b_b = '{8'd100, 8'd100, 8'd100, 8'd0, 8'd0, 8'd0};

    initial begin
        rst      = 1'b1;
        go       = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_outputs("reset");

        run_txn("sum_ok",   b_a, 2, 8'd210, 0, 0, -1, 0, 8'd210, 2'd0, 1, 3);
        run_txn("sum_bad",  b_a, 2, 8'd200, 0, 0, -1, 0, 8'd200, 2'd1, 0, 3);
        run_txn("sum_wrap", b_b, 1, 8'd44,  0, 0, -1, 0, 8'd44,  2'd0, 1, 2);
        run_txn("timeout",  b_a, 2, 8'd210, 1, 0, -1, 0, 8'd0,   2'd3, 0, 256);
`ifdef LAB5_HOST_READBACK_EN
        run_txn("rdbk_bad", b_a, 2, 8'd210, 0, 1, -1, 0, 8'd210, 2'd2, 0, 3);
        run_txn("rdbk_ok",  b_a, 2, 8'd210, 0, 0, -1, 0, 8'd210, 2'd0, 1, 3);
`endif
        run_txn("gap_rst",  b_a, 2, 8'd210, 1, 0, 1, 1,  8'd0,   2'd0, 0, 0);
        run_txn("after_rst", b_b, 3, 8'd44, 0, 0, 3, 0,  8'd44,  2'd0, 1, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lab5_host.md
# lab5_host

Host-side driver for the lab5 sum engine's memory/start/done interface. It accepts a stream of DEPTH bytes, writes them into the engine's memory, and can optionally read them back for checking. It then pulses `start`, waits for `done`, and captures `ans`. `ans` is compared against a locally accumulated modulo-2^DW sum, and the block reports the result with pass/fail and an error code.

## Interface
- `DEPTH`, 6: number of memory entries loaded and summed (1..2^AW)
- `AW`, 3: engine address width
- `DW`, 8: data width
- `TIMEOUT`, 255: maximum cycles to wait for `done` after `start`

- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `go` in 1: begin a transaction; sampled in IDLE only
- `in_valid` in 1: input byte valid
- `in_data` in DW: input byte
- `in_ready` out 1: high in LOAD only
- `addr` out AW: engine address
- `we` out 1: engine write enable
- `din` out DW: engine write data
- `re` out 1: engine read enable
- `dout` in DW: engine read data, valid one cycle after `re`/`addr`
- `start` out 1: single-cycle start pulse
- `done` in 1: engine completion
- `ans` in DW: engine result, sampled when `done`=1
- `busy` out 1: high in any state except IDLE
- `result` out DW: captured `ans`
- `result_valid` out 1: one-cycle pulse in REPORT
- `pass` out 1: held until next `go`
- `err_code` out 2: 0 ok, 1 sum mismatch, 2 readback mismatch, 3 timeout; held until next `go`

## Operation
- All outputs are registered. Reset state: IDLE, every output 0, index 0, accumulator 0, timer 0.
- States: IDLE → LOAD → (VERIFY) → KICK → WAIT → REPORT → IDLE.
- IDLE: `go`=1 clears index, accumulator, `pass`, `err_code`, and `result`; next state LOAD.
- LOAD:
  - `in_ready`=1.
  - Each handshake (`in_valid`&`in_ready`) registers `we`=1, `addr`=index, `din`=`in_data` for the next cycle, adds `in_data` to the accumulator (mod 2^DW), and increments index.
  - A gap on `in_valid` produces `we`=0 that cycle.
  - After the DEPTH-th handshake, `in_ready` drops in the same cycle it registers. The next state is VERIFY if compiled in, otherwise KICK.
  - Index wraps to 0 on leaving LOAD.
- VERIFY:
  - Drives `re`=1 with `addr`=0..DEPTH-1 on consecutive cycles.
  - Compares `dout` one cycle later against a shadow copy of the written bytes.
  - The first mismatch latches `err_code`=2. Entries are still all read.
  - Takes DEPTH+1 cycles, then moves to KICK.
- KICK: `start`=1 for exactly one cycle, `re`=`we`=0; then WAIT with timer cleared.
- WAIT:
  - Timer increments each cycle.
  - `done`=1 captures `ans` into `result`, then REPORT.
  - If the timer reaches TIMEOUT without `done`: `err_code`=3, `result`=0, then REPORT.
  - `done` asserted in the same cycle as `start` is ignored; WAIT samples from the following cycle.
- REPORT:
  - `result_valid`=1 for one cycle.
  - If `err_code`=0 and `result`≠accumulator, set `err_code`=1.
  - `pass`=(final `err_code`==0).
  - Return to IDLE.
- `go` outside IDLE is ignored.
- `rst` mid-transaction returns to IDLE with all outputs 0 on the next edge. Partial writes already made to the engine are not undone.

## Timing
- `go` → first `in_ready`: 1 cycle.
- LOAD handshake at edge n → `we` high during cycle n+1.
- Minimum transaction, verify off, `done` k cycles after `start`: 1 + DEPTH + 1 + k + 1 cycles from `go` to `result_valid`.
- Verify on adds DEPTH+1 cycles.
- `pass` and `err_code` are valid from the `result_valid` cycle onward.

## Configuration
- `LAB5_HOST_READBACK_EN` defined: VERIFY state, shadow register array, and error code 2 are compiled in.
- Undefined: LOAD goes directly to KICK, `re` is tied 0, the shadow array is removed, and `err_code` never equals 2.

## Structure
- Shared package `lab5_pkg`: state enum (IDLE, LOAD, VERIFY, KICK, WAIT, REPORT), error code constants (ERR_OK, ERR_SUM, ERR_RDBK, ERR_TMO), default DEPTH/AW/DW.
- One sub-module, `lab5_host_timeout`: loadable counter with clear, enable, and `expired` output, used by WAIT.

## Test plan
- Load 10,20,30,40,50,60, engine returns `done` with `ans`=210 → `result`=210, `pass`=1, `err_code`=0, `result_valid` one cycle.
- Same load, engine returns `ans`=200 → `pass`=0, `err_code`=1, `result`=200.
- Load 100,100,100,0,0,0 → accumulator 44 (mod 256); engine `ans`=44 → `pass`=1.
- Engine never asserts `done` → after 255 WAIT cycles, `err_code`=3, `result`=0, `pass`=0.
- Readback enabled, engine returns 21 for address 1 → `err_code`=2, `start` still pulses, `pass`=0.
- `in_valid` toggled 1-0-1, plus `rst` asserted during WAIT → `we` shows gaps at the matching cycles; after reset, `busy`=0, `start`=0, outputs 0, and a new `go` completes normally.
